// File: rtl/nv_fifo_ctrl_rws_32x32.sv
// 32x32 FIFO controller driving an external dual-port RAM whose read address is latched by ram_re.
// Define NV_FIFO_CTRL_LVL_EN to add the registered occupancy port fifo_lvl.
module nv_fifo_ctrl_rws_32x32 #(
    parameter int DATA_W = 32
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rstn,
    input  logic              wr_pvld,
    output logic              wr_prdy,
    input  logic [DATA_W-1:0] wr_pd,
    output logic              rd_pvld,
    input  logic              rd_prdy,
    output logic [DATA_W-1:0] rd_pd,
    output logic              ram_we,
    output logic [4:0]        ram_wa,
    output logic [DATA_W-1:0] ram_di,
    output logic              ram_re,
    output logic [4:0]        ram_ra,
    input  logic [DATA_W-1:0] ram_dout
`ifdef NV_FIFO_CTRL_LVL_EN
    ,
    output logic [5:0]        fifo_lvl
`endif
);

    localparam logic [5:0] FULL = 6'd32;

    logic [4:0] wr_ptr;
    logic [4:0] rd_ptr;
    logic [5:0] count;
    logic [5:0] fetch_cnt;
    logic       vld_p1;
    logic       wr_acc_p0;
    logic       fetch_p0;
    logic       pop_p1;

    // Ready comes straight from the occupancy register so rd_prdy never reaches wr_prdy.
    assign wr_prdy   = (count != FULL);
    assign wr_acc_p0 = wr_pvld & wr_prdy;
    assign pop_p1    = vld_p1 & rd_prdy;
    assign fetch_p0  = (fetch_cnt != 6'd0) & (~vld_p1 | rd_prdy);

    assign ram_we = wr_acc_p0;
    assign ram_wa = wr_ptr;
    assign ram_di = wr_pd;
    assign ram_re = fetch_p0;
    assign ram_ra = rd_ptr;

    // Stage p1: RAM output is presented as-is; holding ram_re low keeps it stable under stall.
    assign rd_pvld = vld_p1;
    assign rd_pd   = ram_dout;

`ifdef NV_FIFO_CTRL_LVL_EN
    assign fifo_lvl = count;
`endif

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr    <= 5'd0;
            rd_ptr    <= 5'd0;
            count     <= 6'd0;
            fetch_cnt <= 6'd0;
            vld_p1    <= 1'b0;
        end else begin
            if (wr_acc_p0) begin
                wr_ptr <= wr_ptr + 5'd1;
            end
            if (fetch_p0) begin
                rd_ptr <= rd_ptr + 5'd1;
            end

            case ({wr_acc_p0, pop_p1})
                2'b10:   count <= count + 6'd1;
                2'b01:   count <= count - 6'd1;
                default: count <= count;
            endcase

            // An entry written this cycle only becomes fetchable from the next one.
            case ({wr_acc_p0, fetch_p0})
                2'b10:   fetch_cnt <= fetch_cnt + 6'd1;
                2'b01:   fetch_cnt <= fetch_cnt - 6'd1;
                default: fetch_cnt <= fetch_cnt;
            endcase

            if (fetch_p0) begin
                vld_p1 <= 1'b1;
            end else if (pop_p1) begin
                vld_p1 <= 1'b0;
            end
        end
    end

endmodule
